// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler: picks at most one ready instruction per cycle from the
// int/mult/div/mem issue queues. A reservation shift register books the CDB
// slot each grant will use, so two units never write the CDB in one cycle.
// Also tracks the non-pipelined divider and reports the current CDB owner.
// Optional feature macro: ISSUE_RR_EN (round-robin arbitration). When it is
// undefined, fixed priority div > mult > mem > int is used.
module cdb_issue_scheduler #(
  parameter int INT_LAT  = 1,
  parameter int MEM_LAT  = 1,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 7,
  parameter int DEPTH    = DIV_LAT + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_int,
  input  logic       ready_mult,
  input  logic       ready_div,
  input  logic       ready_mem,
  input  logic       div_exec_ready,
  output logic       issue_int,
  output logic       issue_mult,
  output logic       issue_div,
  output logic       issue_mem,
  output logic [1:0] cdb_owner,
  output logic       cdb_owner_valid,
  output logic       div_busy
);

  // Requester indices
  localparam logic [1:0] IDX_INT  = 2'd0;
  localparam logic [1:0] IDX_MULT = 2'd1;
  localparam logic [1:0] IDX_DIV  = 2'd2;
  localparam logic [1:0] IDX_MEM  = 2'd3;

  // Counter only needs to hold DIV_LAT-1
  localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  // Entry k describes the CDB owner k cycles from now
  logic [DEPTH-1:0] res_valid_q, res_valid_d;
  logic [1:0]       res_owner_q [DEPTH];
  logic [1:0]       res_owner_d [DEPTH];
  logic [CW-1:0]    div_cnt_q, div_cnt_d;

  logic [3:0] elig;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_any;

  // A unit may issue only if the CDB slot its result will need is still free;
  // slot L is read before this edge's shift, so a slot vacated now is reusable.
  always_comb begin
    elig[IDX_INT]  = ready_int  & ~res_valid_q[INT_LAT];
    elig[IDX_MULT] = ready_mult & ~res_valid_q[MULT_LAT];
    elig[IDX_DIV]  = ready_div  & ~res_valid_q[DIV_LAT] & div_exec_ready & (div_cnt_q == '0);
    elig[IDX_MEM]  = ready_mem  & ~res_valid_q[MEM_LAT];
  end

`ifdef ISSUE_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] cand;

  // Round-robin: first eligible requester scanning upward from rr_ptr
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + k[1:0];
      if (!grant_any && elig[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    rr_ptr_d = grant_any ? (grant_idx + 2'd1) : rr_ptr_q;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= 2'd0;
    else      rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority, longest latency first: div > mult > mem > int
  always_comb begin
    grant_any = 1'b1;
    grant_idx = 2'd0;
    if      (elig[IDX_DIV])  grant_idx = IDX_DIV;
    else if (elig[IDX_MULT]) grant_idx = IDX_MULT;
    else if (elig[IDX_MEM])  grant_idx = IDX_MEM;
    else if (elig[IDX_INT])  grant_idx = IDX_INT;
    else                     grant_any = 1'b0;
  end
`endif

  // One-hot grant pulses, suppressed while reset is held low
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grant
      assign grant[gi] = rst & grant_any & (grant_idx == 2'(gi));
    end
  endgenerate

  assign issue_int  = grant[IDX_INT];
  assign issue_mult = grant[IDX_MULT];
  assign issue_div  = grant[IDX_DIV];
  assign issue_mem  = grant[IDX_MEM];

  // Advance the reservation register by one cycle, then book the granted slot
  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      res_valid_d[k] = res_valid_q[k+1];
      res_owner_d[k] = res_owner_q[k+1];
    end
    res_valid_d[DEPTH-1] = 1'b0;
    res_owner_d[DEPTH-1] = 2'd0;
    if (grant_any) begin
      case (grant_idx)
        IDX_INT: begin
          res_valid_d[INT_LAT-1] = 1'b1;
          res_owner_d[INT_LAT-1] = IDX_INT;
        end
        IDX_MULT: begin
          res_valid_d[MULT_LAT-1] = 1'b1;
          res_owner_d[MULT_LAT-1] = IDX_MULT;
        end
        IDX_DIV: begin
          res_valid_d[DIV_LAT-1] = 1'b1;
          res_owner_d[DIV_LAT-1] = IDX_DIV;
        end
        default: begin
          res_valid_d[MEM_LAT-1] = 1'b1;
          res_owner_d[MEM_LAT-1] = IDX_MEM;
        end
      endcase
    end
  end

  // Divider occupancy: load on a div grant, count down to idle otherwise
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (grant_any && (grant_idx == IDX_DIV)) div_cnt_d = CW'(DIV_LAT - 1);
    else if (div_cnt_q != '0)                div_cnt_d = div_cnt_q - CW'(1);
  end

  // State registers; reset discards every in-flight reservation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) res_owner_q[k] <= 2'd0;
      div_cnt_q <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      for (int k = 0; k < DEPTH; k++) res_owner_q[k] <= res_owner_d[k];
      div_cnt_q <= div_cnt_d;
    end
  end

  assign cdb_owner       = res_owner_q[0];
  assign cdb_owner_valid = res_valid_q[0];
  assign div_busy        = (div_cnt_q != '0);

endmodule

// File: doc/cdb_issue_scheduler.md
# cdb_issue_scheduler

Issue scheduler for the out-of-order back end. It picks at most one ready instruction per cycle from the int, mult, div and mem issue queues and drives their issue grants. A CDB reservation shift register guarantees that no two execution units ever write the CDB in the same cycle. It also tracks the non-pipelined divider and tells `cdb_logic` which unit owns the CDB in the current cycle.

## Interface
Parameters:
- `INT_LAT`, 1: cycles from int grant to its result on the CDB (≥1).
- `MEM_LAT`, 1: cycles from mem grant to its result on the CDB (≥1).
- `MULT_LAT`, 4: cycles from mult grant to its result on the CDB (pipelined unit, ≥1).
- `DIV_LAT`, 7: cycles from div grant to its result on the CDB (non-pipelined unit, ≥1).
- `DEPTH`, 8: reservation register length. Must exceed the largest latency; the default is `DIV_LAT+1`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ready_int`, `ready_mult`, `ready_div`, `ready_mem`  in  1 each  issue queue holds a ready instruction.
- `div_exec_ready`  in  1  divider accepts a new operation.
- `issue_int`, `issue_mult`, `issue_div`, `issue_mem`  out  1 each  grant pulses, at most one set per cycle (combinational).
- `cdb_owner`  out  2  unit driving the CDB this cycle: 0 int, 1 mult, 2 div, 3 mem (registered).
- `cdb_owner_valid`  out  1  `cdb_owner` is meaningful (registered).
- `div_busy`  out  1  divider is occupied by an issued operation (registered).

## Operation
- Requester index order: int=0, mult=1, div=2, mem=3.
- Reservation register `res[0..DEPTH-1]`: each entry is a valid bit plus a 2-bit owner. `res[0]` is the current-cycle CDB owner.
- `cdb_owner` and `cdb_owner_valid` are `res[0]`.
- Eligibility of requester X with latency L: `ready_X` is high and `res[L].valid`=0.
- Additional condition for div: `div_exec_ready`=1 and the div counter is 0.
- Arbitration with round-robin compiled in:
  - `rr_ptr[1:0]` marks the highest-priority index.
  - The first eligible requester scanning upward from `rr_ptr` (mod 4) is granted.
  - After a grant to index i, `rr_ptr` <= (i+1) mod 4. With no grant, `rr_ptr` holds.
- Clock-edge update:
  - `res[k]` <= `res[k+1]` for k < DEPTH-1; `res[DEPTH-1]` <= empty.
  - Then, if there was a grant with latency L, `res[L-1]` <= {valid=1, owner=granted index}.
- Div counter:
  - On a div grant, loads `DIV_LAT-1`.
  - Otherwise decrements when nonzero.
  - `div_busy` is high when the counter is nonzero.
- Reset (asynchronous, `rst`=0), applied at any time including mid-operation:
  - All `res` entries invalid, `rr_ptr`=0, div counter 0.
  - `cdb_owner`=0, `cdb_owner_valid`=0, `div_busy`=0.
  - All grants forced to 0 while `rst`=0.
  - In-flight reservations are discarded; the execution units are reset by the same signal.

## Timing
- A grant in cycle t places the result on the CDB in cycle t+L. `cdb_owner_valid`=1 in that cycle with the granted owner.
- Grants are combinational from the `ready_*` inputs and registered state, with zero-cycle latency. The queue treats `issue_X`=1 as consumption at the same edge.
- Simultaneous events:
  - A slot vacated by the shift is reusable in the same cycle, because eligibility reads `res[L]` before the shift.
  - Int and mem with equal latency cannot collide, since only one grant is issued per cycle.
- Full register (every slot valid): no grant; requests simply wait, nothing is dropped.
- Div re-issue is possible at the earliest in cycle t+DIV_LAT, which is the cycle its previous result is on the CDB.
- `ready_X` may drop without a grant; no request state is held internally.

## Configuration
- `ISSUE_RR_EN` defined: round-robin arbitration using `rr_ptr`, as above.
- `ISSUE_RR_EN` undefined:
  - Fixed priority div > mult > mem > int, so longest latency goes first.
  - `rr_ptr` is not implemented.
  - All other behaviour is identical.

## Test plan
- Reset, then all four ready continuously with `div_exec_ready`=1 (`ISSUE_RR_EN` defined):
  - Grants int@c0, mult@c1, div@c2, mem@c3.
  - `cdb_owner_valid` high at c1 (0), c4 (3), c5 (1), c9 (2).
  - The c4–c8 shown cover mem and mult only; the full sequence continues from c4.
- CDB collision:
  - mult granted at c0 (result c4); `ready_int` alone at c3.
  - `issue_int` stays 0 at c3 and pulses at c4. CDB owners: c4=1, c5=0.
- Divider busy:
  - div granted at c0; `ready_div` is held high.
  - `div_busy`=1 over c1–c6; next div grant at c7, not earlier. `div_exec_ready`=0 at c7 delays it to the first cycle it is 1.
- Fixed priority (`ISSUE_RR_EN` undefined), all four ready at c0:
  - `issue_div`=1 at c0.
  - `issue_mult`=1 at c1 (slot 4 free).
  - `issue_mem` at c2, `issue_int` at c3.
- Asynchronous reset mid-operation:
  - Assert `rst`=0 between edges at c3 with 3 reservations in flight.
  - All outputs go to 0 immediately. After release, `cdb_owner_valid` stays 0 until a new grant's latency has elapsed.
